// File: rtl/exmem_cc_pipe_pkg.sv
// y86_pkg: shared Y86-64 constants and types used by the E->M slice.
// Holds icode values, status codes, the "no register" ID, the branch/cmov
// condition encodings carried in ifun, the OPq function encodings and the
// condition-code bundle.
package y86_pkg;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] ICMOV = 4'h2;
  localparam logic [3:0] IOPQ  = 4'h6;
  localparam logic [3:0] IJXX  = 4'h7;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fn_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/exmem_cc_pipe_if.sv
// exmem_cc_pipe_if: bundle between the execute stage / pipeline control
// and the E->M register with condition codes.
//   E-side inputs : e_stat, e_icode, e_ifun, e_aluA, e_aluB, e_valE,
//                   e_valA, e_dstE, e_dstM
//   Status/control: m_stat, W_stat, M_stall, M_bubble
//   Comb outputs  : e_cnd, e_dstE_sel
//   Reg outputs   : cc_out, M_stat, M_icode, M_cnd, M_valE, M_valA,
//                   M_dstE, M_dstM
// master = execute/control side, slave = the pipe register.
interface exmem_cc_pipe_if #(parameter int unsigned WIDTH = 64);
  logic [3:0]       e_stat;
  logic [3:0]       e_icode;
  logic [3:0]       e_ifun;
  logic [WIDTH-1:0] e_aluA;
  logic [WIDTH-1:0] e_aluB;
  logic [WIDTH-1:0] e_valE;
  logic [WIDTH-1:0] e_valA;
  logic [3:0]       e_dstE;
  logic [3:0]       e_dstM;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;
  logic             M_stall;
  logic             M_bubble;
  logic             e_cnd;
  logic [3:0]       e_dstE_sel;
  logic [2:0]       cc_out;
  logic [3:0]       M_stat;
  logic [3:0]       M_icode;
  logic             M_cnd;
  logic [WIDTH-1:0] M_valE;
  logic [WIDTH-1:0] M_valA;
  logic [3:0]       M_dstE;
  logic [3:0]       M_dstM;

  modport master (
    output e_stat, e_icode, e_ifun, e_aluA, e_aluB, e_valE, e_valA,
           e_dstE, e_dstM, m_stat, W_stat, M_stall, M_bubble,
    input  e_cnd, e_dstE_sel, cc_out, M_stat, M_icode, M_cnd, M_valE,
           M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  e_stat, e_icode, e_ifun, e_aluA, e_aluB, e_valE, e_valA,
           e_dstE, e_dstM, m_stat, W_stat, M_stall, M_bubble,
    output e_cnd, e_dstE_sel, cc_out, M_stat, M_icode, M_cnd, M_valE,
           M_valA, M_dstE, M_dstM
  );
endinterface

// File: rtl/exmem_cc_pipe_cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition from ifun and {ZF,SF,OF}.
//   ifun in 4  condition selector
//   cc   in 3  current flags
//   cnd  out 1 condition result (0 for unused encodings 7..15)
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  cc_t        cc,
  output logic       cnd
);
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (cc.sf ^ cc.of) | cc.zf;
      C_L:     cnd = cc.sf ^ cc.of;
      C_E:     cnd = cc.zf;
      C_NE:    cnd = ~cc.zf;
      C_GE:    cnd = ~(cc.sf ^ cc.of);
      C_G:     cnd = ~(cc.sf ^ cc.of) & ~cc.zf;
      default: cnd = 1'b0;
    endcase
  end
endmodule

// File: rtl/exmem_cc_pipe.sv
// exmem_cc_pipe: condition-code register, E-stage condition evaluation and
// the E->M pipeline register with stall/bubble control.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave side of exmem_cc_pipe_if (E inputs, status/control, M outputs)
module exmem_cc_pipe
  import y86_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input logic            clk,
  input logic            rst,
  exmem_cc_pipe_if.slave bus
);
  cc_t              cc_q, cc_d;
  logic             cnd;
  logic             set_cc;
  logic             of_new;
  logic             a_s, b_s, v_s;

  logic [3:0]       m_stat_q,  m_stat_d;
  logic [3:0]       m_icode_q, m_icode_d;
  logic             m_cnd_q,   m_cnd_d;
  logic [WIDTH-1:0] m_vale_q,  m_vale_d;
  logic [WIDTH-1:0] m_vala_q,  m_vala_d;
  logic [3:0]       m_dste_q,  m_dste_d;
  logic [3:0]       m_dstm_q,  m_dstm_d;
  logic [3:0]       dste_sel;

  // Condition uses the registered flags, so an OPq directly ahead of a
  // jXX/cmovXX is visible one cycle later, never in the same cycle.
  cond_eval u_cond_eval (
    .ifun (bus.e_ifun),
    .cc   (cc_q),
    .cnd  (cnd)
  );

  assign dste_sel = (bus.e_icode == ICMOV && !cnd) ? RNONE : bus.e_dstE;

  assign a_s = bus.e_aluA[WIDTH-1];
  assign b_s = bus.e_aluB[WIDTH-1];
  assign v_s = bus.e_valE[WIDTH-1];

  always_comb begin
    of_new = 1'b0;
    case (bus.e_ifun)
      ALU_ADD: of_new = (a_s == b_s) && (v_s != a_s);
      ALU_SUB: of_new = (a_s != b_s) && (v_s != b_s);  // valE = B - A
      default: of_new = 1'b0;
    endcase
  end

  // Stall also covers the stall+bubble error case, keeping CC untouched.
  assign set_cc = (bus.e_icode == IOPQ) && (bus.m_stat == SAOK) &&
                  (bus.W_stat == SAOK) && !bus.M_stall;

  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d.zf = (bus.e_valE == '0);
      cc_d.sf = v_s;
      cc_d.of = of_new;
    end
  end

  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_vale_d  = m_vale_q;
    m_vala_d  = m_vala_q;
    m_dste_d  = m_dste_q;
    m_dstm_d  = m_dstm_q;
    if (bus.M_stall) begin
      // hold
    end else if (bus.M_bubble) begin
      m_stat_d  = SAOK;
      m_icode_d = INOP;
      m_cnd_d   = 1'b0;
      m_vale_d  = '0;
      m_vala_d  = '0;
      m_dste_d  = RNONE;
      m_dstm_d  = RNONE;
    end else begin
      m_stat_d  = bus.e_stat;
      m_icode_d = bus.e_icode;
      m_cnd_d   = cnd;
      m_vale_d  = bus.e_valE;
      m_vala_d  = bus.e_valA;
      m_dste_d  = dste_sel;
      m_dstm_d  = bus.e_dstM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q      <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
      m_stat_q  <= SAOK;
      m_icode_q <= INOP;
      m_cnd_q   <= 1'b0;
      m_vale_q  <= '0;
      m_vala_q  <= '0;
      m_dste_q  <= RNONE;
      m_dstm_q  <= RNONE;
    end else begin
      cc_q      <= cc_d;
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_vale_q  <= m_vale_d;
      m_vala_q  <= m_vala_d;
      m_dste_q  <= m_dste_d;
      m_dstm_q  <= m_dstm_d;
    end
  end

  assign bus.e_cnd      = cnd;
  assign bus.e_dstE_sel = dste_sel;
  assign bus.cc_out     = cc_q;
  assign bus.M_stat     = m_stat_q;
  assign bus.M_icode    = m_icode_q;
  assign bus.M_cnd      = m_cnd_q;
  assign bus.M_valE     = m_vale_q;
  assign bus.M_valA     = m_vala_q;
  assign bus.M_dstE     = m_dste_q;
  assign bus.M_dstM     = m_dstm_q;

endmodule

// File: tb/tb_exmem_cc_pipe.sv
// Directed bench for exmem_cc_pipe: a table of back-to-back E-stage
// instructions with hand-computed flags/conditions, then hand sequences
// for stall, bubble, stall+bubble and asynchronous reset.
module tb_exmem_cc_pipe;
  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exmem_cc_pipe_if #(.WIDTH(W)) bus ();

  exmem_cc_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] v;
    logic [3:0]  dste;
    logic [3:0]  ms;
    logic [3:0]  ws;
    logic        x_cnd;
    logic [3:0]  x_sel;
    logic [2:0]  x_cc;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic vec_t mk(input logic [3:0] ic, input logic [3:0] fn,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] v, input logic [3:0] d,
                              input logic [3:0] ms, input logic [3:0] ws,
                              input logic xc, input logic [3:0] xs,
                              input logic [2:0] xcc);
    vec_t r;
    r.icode = ic; r.ifun = fn; r.a = a; r.b = b; r.v = v; r.dste = d;
    r.ms = ms; r.ws = ws; r.x_cnd = xc; r.x_sel = xs; r.x_cc = xcc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] v,
                       input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] ms, input logic [3:0] ws,
                       input logic stall, input logic bubble);
    bus.e_stat = st; bus.e_icode = ic; bus.e_ifun = fn;
    bus.e_aluA = a; bus.e_aluB = b; bus.e_valE = v; bus.e_valA = va;
    bus.e_dstE = de; bus.e_dstM = dm; bus.m_stat = ms; bus.W_stat = ws;
    bus.M_stall = stall; bus.M_bubble = bubble;
  endtask

  initial begin
    // sequence of instructions; flags carried row to row starting from reset CC=100
    vecs.push_back(mk(6, 1, 5, 5, 0, 3, 1, 1, 1, 3, 3'b100));        // subq -> ZF
    vecs.push_back(mk(7, 4, 0, 0, 64'h100, 15, 1, 1, 0, 15, 3'b100)); // jne
    vecs.push_back(mk(7, 3, 0, 0, 64'h104, 15, 1, 1, 1, 15, 3'b100)); // je
    vecs.push_back(mk(6, 0, MAXP, 1, MINN, 2, 1, 1, 1, 2, 3'b011));  // addq overflow
    vecs.push_back(mk(7, 2, 0, 0, 64'h200, 15, 1, 1, 0, 15, 3'b011)); // jl
    vecs.push_back(mk(7, 1, 0, 0, 64'h204, 15, 1, 1, 0, 15, 3'b011)); // jle
    vecs.push_back(mk(7, 5, 0, 0, 64'h208, 15, 1, 1, 1, 15, 3'b011)); // jge
    vecs.push_back(mk(6, 1, 3, 10, 7, 4, 1, 1, 0, 4, 3'b000));       // subq -> 000
    vecs.push_back(mk(2, 1, 0, 0, 64'h55, 3, 1, 1, 0, 15, 3'b000));  // cmovle not taken
    vecs.push_back(mk(6, 1, 5, 5, 0, 4, 1, 1, 0, 4, 3'b100));        // subq -> ZF
    vecs.push_back(mk(2, 1, 0, 0, 64'h66, 3, 1, 1, 1, 3, 3'b100));   // cmovle taken
    vecs.push_back(mk(6, 0, 1, 2, 3, 5, 1, 1, 1, 5, 3'b000));        // addq -> 000
    vecs.push_back(mk(6, 3, 0, 0, 0, 6, 3, 1, 0, 6, 3'b000));        // xorq, m_stat ADR
    vecs.push_back(mk(6, 3, 0, 0, 0, 6, 1, 2, 0, 6, 3'b000));        // xorq, W_stat HLT
    vecs.push_back(mk(6, 1, 1, 0, ONES, 7, 1, 1, 0, 7, 3'b010));     // subq negative
    vecs.push_back(mk(6, 1, 1, MINN, MAXP, 7, 1, 1, 1, 7, 3'b001));  // subq overflow
    vecs.push_back(mk(6, 2, 0, 0, MINN, 8, 1, 1, 1, 8, 3'b010));     // andq, OF cleared
    vecs.push_back(mk(7, 6, 0, 0, 64'h300, 15, 1, 1, 0, 15, 3'b010)); // jg
    vecs.push_back(mk(7, 7, 0, 0, 64'h304, 15, 1, 1, 0, 15, 3'b010)); // undefined cond
    vecs.push_back(mk(2, 0, 0, 0, 64'h77, 9, 1, 1, 1, 9, 3'b010));   // rrmovq
    vecs.push_back(mk(2, 4, 0, 0, 64'h78, 9, 1, 1, 1, 9, 3'b010));   // cmovne taken
    vecs.push_back(mk(6, 0, MINN, MINN, 0, 10, 1, 1, 1, 10, 3'b101)); // addq neg overflow
    vecs.push_back(mk(7, 1, 0, 0, 64'h400, 15, 1, 1, 1, 15, 3'b101)); // jle
    vecs.push_back(mk(7, 6, 0, 0, 64'h404, 15, 1, 1, 0, 15, 3'b101)); // jg

    drive(4'h1, 4'h1, 4'h0, '0, '0, '0, '0, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset M_icode", 64'(bus.M_icode), 64'h1);
    chk("reset M_stat", 64'(bus.M_stat), 64'h1);
    chk("reset M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("reset M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("reset M_valE", bus.M_valE, 64'h0);
    chk("reset M_cnd", 64'(bus.M_cnd), 64'h0);
    chk("reset cc_out", 64'(bus.cc_out), 64'h4);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      vec_t t;
      t = vecs[i];
      drive(4'h1, t.icode, t.ifun, t.a, t.b, t.v, t.v ^ 64'hA5A5, t.dste, 4'h9,
            t.ms, t.ws, 1'b0, 1'b0);
      #1;
      chk($sformatf("row%0d e_cnd", i), 64'(bus.e_cnd), 64'(t.x_cnd));
      chk($sformatf("row%0d e_dstE_sel", i), 64'(bus.e_dstE_sel), 64'(t.x_sel));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d cc_out", i), 64'(bus.cc_out), 64'(t.x_cc));
      chk($sformatf("row%0d M_icode", i), 64'(bus.M_icode), 64'(t.icode));
      chk($sformatf("row%0d M_cnd", i), 64'(bus.M_cnd), 64'(t.x_cnd));
      chk($sformatf("row%0d M_dstE", i), 64'(bus.M_dstE), 64'(t.x_sel));
      chk($sformatf("row%0d M_valE", i), bus.M_valE, t.v);
      chk($sformatf("row%0d M_valA", i), bus.M_valA, t.v ^ 64'hA5A5);
      chk($sformatf("row%0d M_dstM", i), 64'(bus.M_dstM), 64'h9);
      @(negedge clk);
    end

    // load addq 1+16=17 -> CC 000
    drive(4'h1, 4'h6, 4'h0, 64'h1, 64'h10, 64'h11, 64'hAB, 4'h5, 4'h6, 4'h1, 4'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre-stall cc_out", 64'(bus.cc_out), 64'h0);
    chk("pre-stall M_icode", 64'(bus.M_icode), 64'h6);
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(4'h3, 4'h6, 4'h0, 64'h0, 64'h0, 64'h0, 64'(k + 100), 4'h2, 4'h2,
            4'h1, 4'h1, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d M_icode", k), 64'(bus.M_icode), 64'h6);
      chk($sformatf("stall%0d M_stat", k), 64'(bus.M_stat), 64'h1);
      chk($sformatf("stall%0d M_valE", k), bus.M_valE, 64'h11);
      chk($sformatf("stall%0d M_valA", k), bus.M_valA, 64'hAB);
      chk($sformatf("stall%0d M_dstE", k), 64'(bus.M_dstE), 64'h5);
      chk($sformatf("stall%0d M_dstM", k), 64'(bus.M_dstM), 64'h6);
      chk($sformatf("stall%0d cc_out", k), 64'(bus.cc_out), 64'h0);
    end
    @(negedge clk);
    drive(4'h1, 4'h7, 4'h0, 64'h0, 64'h0, 64'h99, 64'h99, 4'h3, 4'h3, 4'h1, 4'h1, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("bubble M_icode", 64'(bus.M_icode), 64'h1);
    chk("bubble M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("bubble M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("bubble M_valE", bus.M_valE, 64'h0);
    chk("bubble M_valA", bus.M_valA, 64'h0);
    chk("bubble M_cnd", 64'(bus.M_cnd), 64'h0);

    @(negedge clk);
    drive(4'h1, 4'h7, 4'h4, 64'h0, 64'h0, 64'h22, 64'h0, 4'hF, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("jne M_cnd", 64'(bus.M_cnd), 64'h1);
    chk("jne M_icode", 64'(bus.M_icode), 64'h7);
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 4'h1, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("both M_icode", 64'(bus.M_icode), 64'h7);
    chk("both M_valE", bus.M_valE, 64'h22);
    chk("both M_cnd", 64'(bus.M_cnd), 64'h1);
    chk("both cc_out", 64'(bus.cc_out), 64'h0);

    // asynchronous reset in the middle of a cycle after loading an addq
    @(negedge clk);
    drive(4'h1, 4'h6, 4'h0, 64'h1, 64'h32, 64'h33, 64'h7, 4'h4, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre-rst M_icode", 64'(bus.M_icode), 64'h6);
    chk("pre-rst M_valE", bus.M_valE, 64'h33);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst M_icode", 64'(bus.M_icode), 64'h1);
    chk("async rst M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("async rst M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("async rst M_valE", bus.M_valE, 64'h0);
    chk("async rst cc_out", 64'(bus.cc_out), 64'h4);
    @(posedge clk); #1;
    chk("held rst M_icode", 64'(bus.M_icode), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exmem_cc_pipe.md
Name: exmem_cc_pipe

Overview:
- Sits directly downstream of the execute stage (execute_pipe) in the pipelined Y86-64 core.
- Holds the architectural condition-code register (ZF, SF, OF) and evaluates branch/cmov conditions (e_cnd) from it for the instruction currently in E.
- Implements the E→M pipeline register with stall/bubble control.
- Feeds the memory stage and the forwarding logic.

Parameters:
- WIDTH, 64, data word width.
- RNONE, 4'hF, "no register" ID.
- INOP, 4'h1, nop icode inserted on bubble/reset.
- SAOK, 4'h1, status AOK; exception statuses are any value other than SAOK.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- e_stat  in  4  status of the instruction in E.
- e_icode  in  4  icode in E.
- e_ifun  in  4  ifun in E.
- e_aluA  in  WIDTH  ALU operand A (valA for OPq).
- e_aluB  in  WIDTH  ALU operand B (valB for OPq).
- e_valE  in  WIDTH  ALU result from the execute stage.
- e_valA  in  WIDTH  valA passed through to memory.
- e_dstE  in  4  destination register for valE.
- e_dstM  in  4  destination register for valM.
- m_stat  in  4  status currently in M (combinational, for CC gating).
- W_stat  in  4  status currently in W.
- M_stall  in  1  hold the M register.
- M_bubble  in  1  load a nop into the M register.
- e_cnd  out  1  condition result for E (combinational).
- e_dstE_sel  out  4  dstE after cmov suppression (combinational; used for forwarding).
- cc_out  out  3  {ZF, SF, OF} register contents.
- M_stat  out  4  registered status.
- M_icode  out  4  registered icode.
- M_cnd  out  1  registered condition.
- M_valE  out  WIDTH  registered valE.
- M_valA  out  WIDTH  registered valA.
- M_dstE  out  4  registered destination for valE.
- M_dstM  out  4  registered destination for valM.

Behaviour:
- Reset (asynchronous, takes effect immediately, overrides everything):
  - M_icode=INOP, M_stat=SAOK, M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
  - CC: ZF=1, SF=0, OF=0.
  - Release is synchronous to the next clk edge.
- Condition evaluation (combinational, uses current CC register contents, not the same-cycle update). Result by ifun:
  - 0: 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): !ZF
  - 5 (ge): !(SF^OF)
  - 6 (g): !(SF^OF)&!ZF
  - 7–15: 0
- e_cnd is meaningful for icode 2 (cmovXX) and 7 (jXX) only; it is still driven for all icodes.
- e_dstE_sel = RNONE when e_icode==2 and e_cnd==0; otherwise e_dstE.
- CC write enable set_cc = (e_icode==6) & (m_stat==SAOK) & (W_stat==SAOK) & !M_stall. When enabled, the new CC is written on the clk edge:
  - ZF = (e_valE==0).
  - SF = e_valE[WIDTH-1].
  - OF, ifun 0 (addq): aluA and aluB have the same sign and e_valE's sign differs from aluA.
  - OF, ifun 1 (subq, B−A): aluA and aluB have different signs and e_valE's sign differs from aluB.
  - OF, ifun 2/3 and undefined ifun: 0.
- CC result is visible to e_cnd one cycle after the OPq is in E. An OPq immediately followed by jXX/cmovXX therefore sees the updated flags.
- M register update on each clk edge, in priority order:
  1. rst: hold reset values.
  2. M_stall=1: hold all M_* values.
  3. M_bubble=1: load reset values (nop).
  4. Otherwise load: M_stat←e_stat, M_icode←e_icode, M_cnd←e_cnd, M_valE←e_valE, M_valA←e_valA, M_dstE←e_dstE_sel, M_dstM←e_dstM.
- Latency: 1 cycle, E inputs to M outputs.
- M_stall and M_bubble asserted together is a control error. Defined behaviour: stall wins, and CC is not written.
- An exception in M or W blocks the CC write for the OPq in E; the M register still loads unless stalled or bubbled.
- Arithmetic is not recomputed here; e_valE is trusted. Only flags are derived from it.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (INOP, IOPQ=6, ICMOV=2, IJXX=7).
  - ifun condition codes.
  - status codes (SAOK, SHLT, SADR, SINS).
  - RNONE.
- One natural sub-module: cond_eval (combinational; inputs ifun and {ZF,SF,OF}, output cnd). The same sub-module is reusable by the fetch-side branch predictor checks.

Test Plan:
- Reset: assert rst mid-cycle after loading an addq → M_icode=1, M_dstE=F, M_dstM=F, M_valE=0, cc_out=3'b100 immediately, without waiting for clk.
- subq with aluA=5, aluB=5, e_valE=0, stats AOK → next cycle cc_out=100. Then present jne → e_cnd=0; present je → e_cnd=1.
- addq with aluA=64'h7FFF_FFFF_FFFF_FFFF, aluB=1, e_valE=64'h8000_0000_0000_0000 → cc_out=011. Then jl → e_cnd=0, jle → 0, jge → 1.
- cmovle (ifun 1) with cc_out=000, e_dstE=3 → e_dstE_sel=F, next cycle M_dstE=F, M_cnd=0. Then with cc_out=100 → M_dstE=3.
- CC gating: xorq with e_valE=0 while m_stat=3 (ADR) → cc_out unchanged; M_icode=6 still loads.
- Stall/bubble: M_stall=1 for 3 cycles with changing inputs → M_* constant and CC unwritten. Then M_bubble=1 → M_icode=1, M_dstE=F. Both asserted together → hold.
